// File: rtl/sw_pkg.sv
// Shared definitions for the lap stopwatch: state encoding, 7-segment
// patterns ({g,f,e,d,c,b,a}, active-high) and the tick-divider helper.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } sw_state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Last value of the tick counter: one count per CLK_HZ/TICK_HZ clocks.
  function automatic int sw_lst_clk(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz - 1;
  endfunction

endpackage

// File: rtl/fnd_decoder.sv
// Combinational BCD to 7-segment decoder; codes 10-15 blank the digit.
module fnd_decoder
  import sw_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/lap_stopwatch.sv
// N-digit BCD stopwatch with lap-freeze display and sticky overflow flag.
// Optional pause blink of the segment outputs: define SW_PAUSE_BLINK_EN.
module lap_stopwatch
  import sw_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 10,
  parameter int DIGITS      = 3,
  parameter int BLINK_TICKS = 5
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_fStart,
  input  logic                  i_fStop,
  input  logic                  i_fLap,
  output logic [4*DIGITS-1:0]   o_Bcd,
  output logic [7*DIGITS-1:0]   o_Seg,
  output logic                  o_Run,
  output logic                  o_Lap,
  output logic                  o_Ovf
);

  localparam int LST_CLK = sw_lst_clk(CLK_HZ, TICK_HZ);
  localparam int TICK_W  = (LST_CLK > 0) ? $clog2(LST_CLK + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(LST_CLK);

  if (DIGITS < 1 || DIGITS > 8 || BLINK_TICKS < 1 || TICK_HZ < 1 ||
      (CLK_HZ % TICK_HZ) != 0 || (CLK_HZ / TICK_HZ) < 2) begin : g_bad_params
    $error("lap_stopwatch: illegal parameter combination");
  end

  sw_state_e            state, state_nxt;
  logic [TICK_W-1:0]    tick_cnt;
  logic [4*DIGITS-1:0]  count, count_inc, lap_reg;
  logic [7*DIGITS-1:0]  seg_raw;
  logic [DIGITS:0]      carry;
  logic                 ovf;
  logic                 start_prev, stop_prev, lap_prev;
  logic                 start_press, stop_press, lap_press;
  logic                 lap_capture, counting, tick_hit;

  // A held button only yields one press: the pulse needs a released previous sample.
  assign start_press = start_prev & ~i_fStart;
  assign stop_press  = stop_prev  & ~i_fStop;
  assign lap_press   = lap_prev   & ~i_fLap;

  assign counting = (state == RUN) || (state == LAP);
  assign tick_hit = counting && (tick_cnt == TICK_LAST);

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned and infers a latch.
    state_nxt   = state;
    lap_capture = 1'b0;
    case (state)
      IDLE: begin
        if (!stop_press && start_press) state_nxt = RUN;
      end
      RUN: begin
        if (stop_press)       state_nxt = IDLE;
        else if (start_press) state_nxt = PAUSE;
        else if (lap_press) begin
          state_nxt   = LAP;
          lap_capture = 1'b1;
        end
      end
      LAP: begin
        if (stop_press)       state_nxt = IDLE;
        else if (start_press) state_nxt = PAUSE;
        else if (lap_press)   state_nxt = RUN;
      end
      PAUSE: begin
        if (stop_press)       state_nxt = IDLE;
        else if (start_press) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign carry[0] = tick_hit;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] dig;
    assign dig                   = count[4*k +: 4];
    assign carry[k+1]            = carry[k] && (dig == 4'd9);
    assign count_inc[4*k +: 4]   = !carry[k]      ? dig :
                                   (dig == 4'd9)  ? 4'd0 : dig + 4'd1;
    fnd_decoder u_fnd (
      .bcd (o_Bcd[4*k +: 4]),
      .seg (seg_raw[7*k +: 7])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      count      <= '0;
      lap_reg    <= '0;
      ovf        <= 1'b0;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
      lap_prev   <= 1'b1;
    end else begin
      start_prev <= i_fStart;
      stop_prev  <= i_fStop;
      lap_prev   <= i_fLap;
      state      <= state_nxt;
      if (state_nxt == IDLE) begin
        tick_cnt <= '0;
        count    <= '0;
        ovf      <= 1'b0;
      end else if (counting) begin
        tick_cnt <= tick_hit ? '0 : tick_cnt + 1'b1;
        count    <= count_inc;
        if (carry[DIGITS]) ovf <= 1'b1;
      end
      if (lap_capture) lap_reg <= count;
    end
  end

  assign o_Bcd = (state == LAP) ? lap_reg : count;
  assign o_Run = counting;
  assign o_Lap = (state == LAP);
  assign o_Ovf = ovf;

`ifdef SW_PAUSE_BLINK_EN
  localparam int BLINK_W = (2 * BLINK_TICKS > 1) ? $clog2(2 * BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_TICKS);

  logic [TICK_W-1:0]  blink_div;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blank;

  // The divider restarts on PAUSE entry so the visible half-period is always full length.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || state != PAUSE) begin
      blink_div <= '0;
      blink_cnt <= '0;
    end else if (blink_div == TICK_LAST) begin
      blink_div <= '0;
      blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
    end else begin
      blink_div <= blink_div + 1'b1;
    end
  end

  assign blank = (state == PAUSE) && (blink_cnt >= BLINK_HALF);
  assign o_Seg = blank ? '0 : seg_raw;
`else
  assign o_Seg = seg_raw;
`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed self-checking bench for lap_stopwatch (CLK_HZ=10, TICK_HZ=1, DIGITS=3).
module tb_lap_stopwatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_start = 1'b1;
  logic        f_stop  = 1'b1;
  logic        f_lap   = 1'b1;
  logic [11:0] bcd;
  logic [20:0] seg;
  logic        run, lap, ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lap_stopwatch #(
    .CLK_HZ      (10),
    .TICK_HZ     (1),
    .DIGITS      (3),
    .BLINK_TICKS (5)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_fStart (f_start),
    .i_fStop  (f_stop),
    .i_fLap   (f_lap),
    .o_Bcd    (bcd),
    .o_Seg    (seg),
    .o_Run    (run),
    .o_Lap    (lap),
    .o_Ovf    (ovf)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [20:0] seg3(input logic [11:0] v);
    return {seg_of(v[11:8]), seg_of(v[7:4]), seg_of(v[3:0])};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle press of the selected buttons; the state changes on that edge.
  task automatic press(input logic s, input logic p, input logic l);
    f_start = ~s;
    f_stop  = ~p;
    f_lap   = ~l;
    step(1);
    f_start = 1'b1;
    f_stop  = 1'b1;
    f_lap   = 1'b1;
  endtask

  initial begin
    // 1. reset state, start, first increment, 120 cycles
    step(2);
    rst = 1'b0;
    check("rst_bcd", bcd, 12'h000);
    check("rst_seg", seg, seg3(12'h000));
    check("rst_run", run, 1'b0);
    check("rst_lap", lap, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    step(1);
    press(1, 0, 0);
    check("start_run", run, 1'b1);
    step(9);
    check("before_first_inc", bcd, 12'h000);
    step(1);
    check("first_inc", bcd, 12'h001);
    step(110);
    check("run120_bcd", bcd, 12'h012);
    check("run120_seg", seg, seg3(12'h012));
    check("run120_run", run, 1'b1);

    // 2. overflow and stop
    step(9870);
    check("at_999_bcd", bcd, 12'h999);
    check("at_999_seg", seg, seg3(12'h999));
    check("at_999_ovf", ovf, 1'b0);
    step(10);
    check("wrap_bcd", bcd, 12'h000);
    check("wrap_ovf", ovf, 1'b1);
    check("wrap_run", run, 1'b1);
    step(1);
    press(0, 1, 0);
    check("stop_run", run, 1'b0);
    check("stop_ovf", ovf, 1'b0);
    check("stop_bcd", bcd, 12'h000);

    // 3. lap freeze and release
    step(1);
    press(1, 0, 0);
    step(50);
    check("pre_lap_bcd", bcd, 12'h005);
    press(0, 0, 1);
    check("lap_flag", lap, 1'b1);
    check("lap_run", run, 1'b1);
    check("lap_hold0", bcd, 12'h005);
    step(25);
    check("lap_hold25", bcd, 12'h005);
    step(24);
    check("lap_hold49", bcd, 12'h005);
    press(0, 0, 1);
    check("lap_exit_flag", lap, 1'b0);
    check("lap_exit_live", bcd, 12'h010);

    // 4. pause keeps sub-tick phase
    step(1);
    press(0, 1, 0);
    step(1);
    press(1, 0, 0);
    step(34);
    check("pre_pause_bcd", bcd, 12'h003);
    press(1, 0, 0);
    check("pause_run", run, 1'b0);
    check("pause_lap", lap, 1'b0);
    check("pause_bcd", bcd, 12'h003);
`ifdef SW_PAUSE_BLINK_EN
    step(49);
    check("blink_vis49", seg, seg3(12'h003));
    step(1);
    check("blink_off50", seg, 21'h0);
    step(49);
    check("blink_off99", seg, 21'h0);
    step(1);
    check("blink_vis100", seg, seg3(12'h003));
    check("blink_bcd", bcd, 12'h003);
`endif
    step(10);
    press(0, 0, 1);
    check("pause_lap_ignored", lap, 1'b0);
    check("pause_lap_run", run, 1'b0);
    step(89);
    check("pause_hold_bcd", bcd, 12'h003);
    press(1, 0, 0);
    check("resume_run", run, 1'b1);
    step(4);
    check("resume_4", bcd, 12'h003);
    step(1);
    check("resume_5", bcd, 12'h004);

    // 5. priority, held button, reset mid-run
    step(1);
    press(1, 1, 0);
    check("start_stop_run", run, 1'b0);
    check("start_stop_bcd", bcd, 12'h000);
    step(1);
    f_start = 1'b0;
    step(1);
    check("held_enter", run, 1'b1);
    step(49);
    check("held_run", run, 1'b1);
    check("held_bcd", bcd, 12'h004);
    f_start = 1'b1;
    step(1);
    press(1, 0, 1);
    check("start_lap_run", run, 1'b0);
    check("start_lap_lap", lap, 1'b0);
    step(1);
    press(1, 0, 0);
    check("rerun", run, 1'b1);
    step(3);
    rst = 1'b1;
    step(1);
    check("midrst_bcd", bcd, 12'h000);
    check("midrst_run", run, 1'b0);
    check("midrst_lap", lap, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    rst = 1'b0;
    step(2);
    check("post_rst_idle", run, 1'b0);
    press(0, 0, 1);
    check("idle_lap_ignored", lap, 1'b0);
    check("idle_lap_run", run, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
- Parametrised successor to the 3-digit FND stopwatch: N-digit BCD stopwatch with configurable tick rate, lap-freeze display, overflow flag and per-digit 7-segment outputs.
- Sits between debounced front-panel buttons and the FND display bank.
- Counting continues while a lap time is held on the display.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- TICK_HZ, 10, count rate in Hz; LST_CLK = CLK_HZ/TICK_HZ - 1. CLK_HZ must be an integer multiple of TICK_HZ, and the ratio must be ≥ 2.
- DIGITS, 3, number of BCD digits, range 1..8.
- BLINK_TICKS, 5, half-period of the pause blink, in ticks. Used only with the optional feature.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset; synchronous, active-high.
- i_fStart  in  1  start/pause button, active-low, already debounced.
- i_fStop  in  1  stop/clear button, active-low, already debounced.
- i_fLap  in  1  lap button, active-low, already debounced.
- o_Bcd  out  4*DIGITS  displayed value; digit k occupies [4k+3:4k]; digit 0 is least significant.
- o_Seg  out  7*DIGITS  segments for digit k at [7k+6:7k], order {g,f,e,d,c,b,a}, active-high.
- o_Run  out  1  high in RUN and LAP states.
- o_Lap  out  1  high in LAP state.
- o_Ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (i_Rst=1 at a clock edge): state IDLE; tick counter, count, lap register and o_Ovf cleared to 0; button history registers set to 1 (released). Reset mid-run aborts immediately with no residual press.
- Press detect: each button is registered. A press is a 1-cycle pulse when the previous sample is 1 and the current input is 0. The state changes on the edge after the pulse. A held button produces exactly one press.
- Priority when presses coincide: stop > start > lap.
- IDLE:
  - Count, tick counter and o_Ovf held at 0.
  - start → RUN; lap is ignored.
- RUN:
  - Tick counter runs 0..LST_CLK and wraps. The count increments on the cycle where the tick counter equals LST_CLK, so the first increment occurs LST_CLK+1 cycles after entering RUN.
  - Digit k increments when all lower digits are 9, wrapping 9→0.
  - At all-9s, the next tick wraps the count to 0 and sets o_Ovf. o_Ovf stays high until IDLE or reset.
  - stop → IDLE; start → PAUSE; lap → capture the count into the lap register, then → LAP.
- LAP: counting continues as in RUN while o_Bcd shows the lap register.
  - lap → RUN (live display).
  - start → PAUSE.
  - stop → IDLE.
- PAUSE:
  - Tick counter and count frozen; the tick counter is not cleared, so resume preserves the sub-tick phase.
  - start → RUN; stop → IDLE; lap ignored.
- Display: o_Bcd = lap register in LAP, otherwise the live count. o_Seg is a combinational decode of o_Bcd. BCD values 10–15 never occur; the decoder drives all segments off for them.
- Latency: press edge to state change is 1 cycle from the input sample. The count, o_Bcd and o_Seg outputs are registered/decoded with no extra delay.

Optional Feature:
- Macro SW_PAUSE_BLINK_EN.
- Defined:
  - In PAUSE, a blink counter advances on tick-rate strobes generated by a free-running divider. The pause tick counter stays frozen.
  - o_Seg is forced to all-0 for BLINK_TICKS ticks, then shown for BLINK_TICKS ticks, repeating. Display starts visible on PAUSE entry.
  - o_Bcd is unaffected.
- Undefined: no blink logic; o_Seg always decodes o_Bcd.

Decomposition:
- Shared package sw_pkg:
  - State encoding: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11.
  - Constants: segment patterns for 0–9 and blank.
  - Function sw_lst_clk(CLK_HZ, TICK_HZ).
- One sub-module, fnd_decoder: 4-bit BCD in, 7-bit segments out, combinational. Instantiated DIGITS times via generate.
- Digit cascade stays inline in a generate loop.

Test Plan:
Common bench parameters: CLK_HZ=10, TICK_HZ=1 (LST_CLK=9), DIGITS=3.
1. Reset, start press, run 120 cycles → o_Bcd=0x012, o_Run=1; first increment at cycle 10 after RUN entry.
2. Run to 0x999, one more tick → o_Bcd=0x000, o_Ovf=1. Stop press → IDLE, o_Ovf=0, o_Bcd=0x000.
3. At count 0x005, lap press → o_Lap=1, o_Bcd holds 0x005 for 50 cycles. Lap press again → o_Bcd shows the live 0x010.
4. At 0x003 with tick counter=4, start press (PAUSE), wait 100 cycles, start press → next increment to 0x004 arrives 5 cycles after resume.
5. Start and stop pressed in the same cycle while in RUN → IDLE. A button held low for 50 cycles gives exactly one transition. i_Rst=1 during RUN → all outputs 0 on the next edge.
6. With SW_PAUSE_BLINK_EN and BLINK_TICKS=5: in PAUSE, o_Seg is nonzero for 50 cycles, all-0 for 50 cycles, repeating. o_Bcd is constant throughout.
